mor1kx_wb_arbiter_marocchino: RTL and testbench
===============================================

// Module: mor1kx_wb_arbiter_marocchino
//
// PURPOSE
//  Write-back stage arbiter for the MAROCCHINO pipeline.
//  - Collects completed results from four execution units: ALU, MUL, DIV and LSU.
//  - Grants at most one unit per cycle and registers its result into the WB latch.
//  - Drives the WB-side inputs of the register file: wb_rf_wb, wb_rfd_adr, wb_result and wb_new_result.
//  - Uses an aging counter per unit so that no unit starves.
//
// PARAMETERS
//  OPTION_OPERAND_WIDTH  32  result data width
//  OPTION_RF_ADDR_WIDTH   5  GPR address width
//  AGE_MAX                3  wait cycles before a unit is promoted (1..7, 3-bit counter)
//
// PORTS  (<u> = alu | mul | div | lsu; one set of five ports per unit)
//  clk               in   1     clock
//  rst               in   1     synchronous active-high reset
//  pipeline_flush_i  in   1     drop all pending and granted results
//  wb_stall_i        in   1     CTRL holds WB (SPR access); no grant while high
//  <u>_valid_i       in   1     unit holds a completed result
//  <u>_rf_wb_i       in   1     result is to be written into a GPR
//  <u>_rfd_adr_i     in   AW    destination GPR
//  <u>_result_i      in   DW    result data
//  <u>_taken_o       out  1     grant; the unit releases its result after this cycle
//  wb_rf_wb_o        out  1     WB latch holds a GPR write
//  wb_rfd_adr_o      out  AW    WB destination
//  wb_result_o       out  DW    WB data
//  wb_new_result_o   out  1     1-cycle pulse: WB latch was loaded on the last edge
//
// BEHAVIOUR
//  Reset
//   - All outputs are 0.
//   - Aging counters are 0.
//  Handshake
//   - A unit raises <u>_valid_i and holds valid, rf_wb, adr and result stable until it sees <u>_taken_o.
//   - <u>_taken_o is combinational in the same cycle.
//   - The unit drops valid on the next cycle unless it has a new result ready.
//   - Grant condition: any valid, and ~wb_stall_i, and ~pipeline_flush_i.
//   - At most one taken_o is asserted per cycle (one-hot or zero).
//  Priority
//   - Promoted units go first, where promoted means age == AGE_MAX.
//   - Then fixed order: LSU > DIV > MUL > ALU.
//   - Among promoted units the same fixed order applies.
//  Aging (3-bit counter per unit)
//   - Counter +1 each cycle the unit is valid but not granted, saturating at AGE_MAX.
//   - Counter cleared on grant, on ~valid, on flush and on reset.
//   - The counter does not advance while wb_stall_i is high (it holds).
//  WB latch, loaded on the edge that ends a grant cycle
//   - wb_rf_wb_o, wb_rfd_adr_o and wb_result_o take the granted unit's values.
//   - wb_new_result_o is 1 for exactly the following cycle.
//   - Net latency: valid and granted in cycle N gives WB data and the pulse in cycle N+1.
//   - Without a grant, wb_new_result_o is 0 and adr/result hold their last values.
//   - wb_rf_wb_o also holds, so the RF's decode hazard compare remains valid.
//   - A granted result with rf_wb=0 (stores, branches) loads wb_rf_wb_o=0 and still pulses wb_new_result_o.
//  Flush
//   - In the flush cycle all taken_o are 0.
//   - On the following edge wb_rf_wb_o <= 0 and wb_new_result_o <= 0; adr/result hold; counters clear.
//   - Flush has priority over stall and over grant.
//  Simultaneous events
//   - Several units valid: one is granted, the others wait and age.
//   - Back-to-back grants are allowed every cycle, giving a sustained rate of 1 result/cycle.
//   - Reset mid-operation: same as the reset state; pending unit results are not latched.
//  Width rules
//   - No arithmetic on data; adr and result pass through unmodified (r0 writes included).
//
// TESTING
//  1. Single ALU result: alu_valid=1, adr=5, res=0x1234 in cycle N
//     -> alu_taken=1 in N; in N+1 wb_rf_wb=1, adr=5, res=0x1234, new_result=1; in N+2 new_result=0.
//  2. All four valid in cycle N, AGE_MAX=3
//     -> grant order lsu, div, mul, alu across N..N+3; 4 consecutive new_result pulses; never two taken_o together.
//  3. Starvation: lsu valid continuously with a new result each grant; alu valid from cycle N
//     -> alu ages 1,2,3 and is granted in N+3; lsu is granted in N..N+2 and again in N+4.
//  4. wb_stall=1 for 5 cycles with mul valid
//     -> mul_taken=0 and age frozen throughout; grant in the first cycle after stall drops.
//  5. Flush in the same cycle as div_valid
//     -> div_taken=0; next cycle wb_rf_wb=0, new_result=0; a following grant works normally.
//  6. lsu result with rf_wb=0, then alu adr=3 with rf_wb=1
//     -> first pulse shows wb_rf_wb=0; second pulse wb_rf_wb=1, adr=3.

Source files
------------

// File: rtl/mor1kx_wb_arbiter_marocchino_if.sv
// Execution-unit result handshakes and WB latch outputs for the MAROCCHINO write-back arbiter.
// master: the execution units and the register file side. slave: the arbiter.
interface mor1kx_wb_arbiter_marocchino_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic          alu_valid_i;
  logic          alu_rf_wb_i;
  logic [AW-1:0] alu_rfd_adr_i;
  logic [DW-1:0] alu_result_i;
  logic          alu_taken_o;

  logic          mul_valid_i;
  logic          mul_rf_wb_i;
  logic [AW-1:0] mul_rfd_adr_i;
  logic [DW-1:0] mul_result_i;
  logic          mul_taken_o;

  logic          div_valid_i;
  logic          div_rf_wb_i;
  logic [AW-1:0] div_rfd_adr_i;
  logic [DW-1:0] div_result_i;
  logic          div_taken_o;

  logic          lsu_valid_i;
  logic          lsu_rf_wb_i;
  logic [AW-1:0] lsu_rfd_adr_i;
  logic [DW-1:0] lsu_result_i;
  logic          lsu_taken_o;

  logic          wb_rf_wb_o;
  logic [AW-1:0] wb_rfd_adr_o;
  logic [DW-1:0] wb_result_o;
  logic          wb_new_result_o;

  modport master (
    output alu_valid_i, alu_rf_wb_i, alu_rfd_adr_i, alu_result_i,
    output mul_valid_i, mul_rf_wb_i, mul_rfd_adr_i, mul_result_i,
    output div_valid_i, div_rf_wb_i, div_rfd_adr_i, div_result_i,
    output lsu_valid_i, lsu_rf_wb_i, lsu_rfd_adr_i, lsu_result_i,
    input  alu_taken_o, mul_taken_o, div_taken_o, lsu_taken_o,
    input  wb_rf_wb_o, wb_rfd_adr_o, wb_result_o, wb_new_result_o
  );

  modport slave (
    input  alu_valid_i, alu_rf_wb_i, alu_rfd_adr_i, alu_result_i,
    input  mul_valid_i, mul_rf_wb_i, mul_rfd_adr_i, mul_result_i,
    input  div_valid_i, div_rf_wb_i, div_rfd_adr_i, div_result_i,
    input  lsu_valid_i, lsu_rf_wb_i, lsu_rfd_adr_i, lsu_result_i,
    output alu_taken_o, mul_taken_o, div_taken_o, lsu_taken_o,
    output wb_rf_wb_o, wb_rfd_adr_o, wb_result_o, wb_new_result_o
  );
endinterface

// File: rtl/mor1kx_wb_arbiter_marocchino.sv
// Write-back arbiter: grants one of ALU/MUL/DIV/LSU per cycle into the WB latch,
// fixed priority LSU > DIV > MUL > ALU with per-unit aging to prevent starvation.
module mor1kx_wb_arbiter_marocchino #(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned OPTION_RF_ADDR_WIDTH = 5,
  parameter int unsigned AGE_MAX              = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pipeline_flush_i,
  input  logic                            wb_stall_i,
  mor1kx_wb_arbiter_marocchino_if.slave   bus
);

  localparam int unsigned DW = OPTION_OPERAND_WIDTH;
  localparam int unsigned AW = OPTION_RF_ADDR_WIDTH;
  localparam int IdxAlu = 0;
  localparam int IdxMul = 1;
  localparam int IdxDiv = 2;
  localparam int IdxLsu = 3;
  localparam logic [2:0] AgeMax = 3'(AGE_MAX);

  logic [3:0]    valid;
  logic [3:0]    rf_wb;
  logic [AW-1:0] adr [4];
  logic [DW-1:0] res [4];

  logic [3:0]    promoted;
  logic [3:0]    cand;
  logic [3:0]    grant;
  logic          grant_en;

  logic          sel_rf_wb;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_res;

  logic [2:0]    age_q [4];
  logic [2:0]    age_d [4];
  logic          wb_rf_wb_q, wb_rf_wb_d;
  logic [AW-1:0] wb_adr_q, wb_adr_d;
  logic [DW-1:0] wb_res_q, wb_res_d;
  logic          wb_new_q, wb_new_d;

  always_comb begin
    valid       = {bus.lsu_valid_i, bus.div_valid_i, bus.mul_valid_i, bus.alu_valid_i};
    rf_wb       = {bus.lsu_rf_wb_i, bus.div_rf_wb_i, bus.mul_rf_wb_i, bus.alu_rf_wb_i};
    adr[IdxAlu] = bus.alu_rfd_adr_i;
    adr[IdxMul] = bus.mul_rfd_adr_i;
    adr[IdxDiv] = bus.div_rfd_adr_i;
    adr[IdxLsu] = bus.lsu_rfd_adr_i;
    res[IdxAlu] = bus.alu_result_i;
    res[IdxMul] = bus.mul_result_i;
    res[IdxDiv] = bus.div_result_i;
    res[IdxLsu] = bus.lsu_result_i;
  end

  // Promoted units form the candidate set when any exist; fixed order resolves within it.
  always_comb begin
    grant_en = (|valid) && !wb_stall_i && !pipeline_flush_i && !rst;
    for (int i = 0; i < 4; i++) begin
      promoted[i] = valid[i] && (age_q[i] == AgeMax);
    end
    cand  = (|promoted) ? promoted : valid;
    grant = '0;
    if (grant_en) begin
      if (cand[IdxLsu])      grant[IdxLsu] = 1'b1;
      else if (cand[IdxDiv]) grant[IdxDiv] = 1'b1;
      else if (cand[IdxMul]) grant[IdxMul] = 1'b1;
      else if (cand[IdxAlu]) grant[IdxAlu] = 1'b1;
    end
  end

  always_comb begin
    sel_rf_wb = 1'b0;
    sel_adr   = '0;
    sel_res   = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) begin
        sel_rf_wb = rf_wb[i];
        sel_adr   = adr[i];
        sel_res   = res[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      age_d[i] = age_q[i];
      if (pipeline_flush_i || !valid[i] || grant[i]) begin
        age_d[i] = '0;
      end else if (!wb_stall_i && (age_q[i] < AgeMax)) begin
        age_d[i] = age_q[i] + 3'd1;
      end
    end
  end

  // adr/result hold across flush so the last committed destination stays visible.
  always_comb begin
    wb_rf_wb_d = wb_rf_wb_q;
    wb_adr_d   = wb_adr_q;
    wb_res_d   = wb_res_q;
    wb_new_d   = 1'b0;
    if (pipeline_flush_i) begin
      wb_rf_wb_d = 1'b0;
    end else if (|grant) begin
      wb_rf_wb_d = sel_rf_wb;
      wb_adr_d   = sel_adr;
      wb_res_d   = sel_res;
      wb_new_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) age_q[i] <= '0;
      wb_rf_wb_q <= 1'b0;
      wb_adr_q   <= '0;
      wb_res_q   <= '0;
      wb_new_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) age_q[i] <= age_d[i];
      wb_rf_wb_q <= wb_rf_wb_d;
      wb_adr_q   <= wb_adr_d;
      wb_res_q   <= wb_res_d;
      wb_new_q   <= wb_new_d;
    end
  end

  assign bus.alu_taken_o     = grant[IdxAlu];
  assign bus.mul_taken_o     = grant[IdxMul];
  assign bus.div_taken_o     = grant[IdxDiv];
  assign bus.lsu_taken_o     = grant[IdxLsu];
  assign bus.wb_rf_wb_o      = wb_rf_wb_q;
  assign bus.wb_rfd_adr_o    = wb_adr_q;
  assign bus.wb_result_o     = wb_res_q;
  assign bus.wb_new_result_o = wb_new_q;

endmodule

// File: tb/tb_mor1kx_wb_arbiter_marocchino.sv
// Directed, table-driven bench for the MAROCCHINO write-back arbiter.
module tb_mor1kx_wb_arbiter_marocchino;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic stall;

  int n_checks = 0;
  int n_fail   = 0;

  mor1kx_wb_arbiter_marocchino_if #(.DW(32), .AW(5)) bus ();

  mor1kx_wb_arbiter_marocchino #(
    .OPTION_OPERAND_WIDTH (32),
    .OPTION_RF_ADDR_WIDTH (5),
    .AGE_MAX              (3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .pipeline_flush_i (flush),
    .wb_stall_i       (stall),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  // Bit order of all 4-bit masks: {lsu, div, mul, alu}.
  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  rf_wb;
    logic        stall;
    logic        flush;
    logic [3:0]  taken;
    logic        new_res;
    logic        wb_rf_wb;
    logic [4:0]  adr;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] v, logic [3:0] w, logic s, logic f, logic [3:0] t,
                              logic n, logic r, logic [4:0] a, logic [31:0] d);
    vec_t x;
    x.valid = v; x.rf_wb = w; x.stall = s; x.flush = f; x.taken = t;
    x.new_res = n; x.wb_rf_wb = r; x.adr = a; x.res = d;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] w, input logic s, input logic f);
    bus.alu_valid_i = v[0]; bus.alu_rf_wb_i = w[0];
    bus.mul_valid_i = v[1]; bus.mul_rf_wb_i = w[1];
    bus.div_valid_i = v[2]; bus.div_rf_wb_i = w[2];
    bus.lsu_valid_i = v[3]; bus.lsu_rf_wb_i = w[3];
    stall = s;
    flush = f;
  endtask

  function automatic logic [3:0] taken_vec();
    return {bus.lsu_taken_o, bus.div_taken_o, bus.mul_taken_o, bus.alu_taken_o};
  endfunction

  task automatic check_wb(input string tag, input logic n, input logic r, input logic [4:0] a,
                          input logic [31:0] d);
    check({tag, " new_result"}, 32'(bus.wb_new_result_o), 32'(n));
    check({tag, " rf_wb"}, 32'(bus.wb_rf_wb_o), 32'(r));
    check({tag, " adr"}, 32'(bus.wb_rfd_adr_o), 32'(a));
    check({tag, " result"}, bus.wb_result_o, d);
  endtask

  initial begin
    // Fixed per-unit payloads: alu(5,1234) mul(6,6666) div(7,7777) lsu(8,8888).
    bus.alu_rfd_adr_i = 5'd5; bus.alu_result_i = 32'h0000_1234;
    bus.mul_rfd_adr_i = 5'd6; bus.mul_result_i = 32'h0000_6666;
    bus.div_rfd_adr_i = 5'd7; bus.div_result_i = 32'h0000_7777;
    bus.lsu_rfd_adr_i = 5'd8; bus.lsu_result_i = 32'h0000_8888;
    drive(4'b0000, 4'b1111, 1'b0, 1'b0);
    rst = 1'b1;

    // Single ALU result, then idle hold
    vecs.push_back(mk(4'b0001, 4'b1111, 0, 0, 4'b0001, 1, 1, 5'd5, 32'h1234));
    vecs.push_back(mk(4'b0000, 4'b1111, 0, 0, 4'b0000, 0, 1, 5'd5, 32'h1234));
    // All four valid: lsu, div, mul, alu
    vecs.push_back(mk(4'b1111, 4'b1111, 0, 0, 4'b1000, 1, 1, 5'd8, 32'h8888));
    vecs.push_back(mk(4'b0111, 4'b1111, 0, 0, 4'b0100, 1, 1, 5'd7, 32'h7777));
    vecs.push_back(mk(4'b0011, 4'b1111, 0, 0, 4'b0010, 1, 1, 5'd6, 32'h6666));
    vecs.push_back(mk(4'b0001, 4'b1111, 0, 0, 4'b0001, 1, 1, 5'd5, 32'h1234));
    vecs.push_back(mk(4'b0000, 4'b1111, 0, 0, 4'b0000, 0, 1, 5'd5, 32'h1234));
    // alu ages to 1, stall freezes it, then 2, 3 and promotion beats lsu
    vecs.push_back(mk(4'b1001, 4'b1111, 0, 0, 4'b1000, 1, 1, 5'd8, 32'h8888));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'b1001, 4'b1111, 1, 0, 4'b0000, 0, 1, 5'd8, 32'h8888));
    vecs.push_back(mk(4'b1001, 4'b1111, 0, 0, 4'b1000, 1, 1, 5'd8, 32'h8888));
    vecs.push_back(mk(4'b1001, 4'b1111, 0, 0, 4'b1000, 1, 1, 5'd8, 32'h8888));
    vecs.push_back(mk(4'b1001, 4'b1111, 0, 0, 4'b0001, 1, 1, 5'd5, 32'h1234));
    vecs.push_back(mk(4'b1000, 4'b1111, 0, 0, 4'b1000, 1, 1, 5'd8, 32'h8888));
    // Starvation from scratch: lsu N..N+2, alu N+3, lsu N+4
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(4'b1001, 4'b1111, 0, 0, 4'b1000, 1, 1, 5'd8, 32'h8888));
    vecs.push_back(mk(4'b1001, 4'b1111, 0, 0, 4'b0001, 1, 1, 5'd5, 32'h1234));
    vecs.push_back(mk(4'b1000, 4'b1111, 0, 0, 4'b1000, 1, 1, 5'd8, 32'h8888));
    // lsu without GPR write still pulses, then alu with write
    vecs.push_back(mk(4'b1000, 4'b0000, 0, 0, 4'b1000, 1, 0, 5'd8, 32'h8888));
    vecs.push_back(mk(4'b0001, 4'b1111, 0, 0, 4'b0001, 1, 1, 5'd5, 32'h1234));
    // Flush with div valid, then normal grant
    vecs.push_back(mk(4'b0100, 4'b1111, 0, 1, 4'b0000, 0, 0, 5'd5, 32'h1234));
    vecs.push_back(mk(4'b0100, 4'b1111, 0, 0, 4'b0100, 1, 1, 5'd7, 32'h7777));
    // Flush (over stall) clears alu's age
    vecs.push_back(mk(4'b1001, 4'b1111, 0, 0, 4'b1000, 1, 1, 5'd8, 32'h8888));
    vecs.push_back(mk(4'b1001, 4'b1111, 1, 1, 4'b0000, 0, 0, 5'd8, 32'h8888));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(4'b1001, 4'b1111, 0, 0, 4'b1000, 1, 1, 5'd8, 32'h8888));
    vecs.push_back(mk(4'b1001, 4'b1111, 0, 0, 4'b0001, 1, 1, 5'd5, 32'h1234));
    vecs.push_back(mk(4'b0000, 4'b1111, 0, 0, 4'b0000, 0, 1, 5'd5, 32'h1234));
    // mul held off by a 5-cycle stall, granted right after
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'b0010, 4'b1111, 1, 0, 4'b0000, 0, 1, 5'd5, 32'h1234));
    vecs.push_back(mk(4'b0010, 4'b1111, 0, 0, 4'b0010, 1, 1, 5'd6, 32'h6666));

    repeat (2) @(posedge clk);
    #1;
    check("reset taken", 32'(taken_vec()), 32'h0);
    check_wb("reset", 1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].rf_wb, vecs[i].stall, vecs[i].flush);
      #1;
      check($sformatf("vec%0d taken", i), 32'(taken_vec()), 32'(vecs[i].taken));
      @(posedge clk);
      #1;
      check_wb($sformatf("vec%0d", i), vecs[i].new_res, vecs[i].wb_rf_wb, vecs[i].adr,
               vecs[i].res);
    end

    // Reset mid-operation: alu has aged to 2; reset must clear it and the WB latch
    @(negedge clk);
    drive(4'b1001, 4'b1111, 1'b0, 1'b0);
    #1 check("pre-rst taken0", 32'(taken_vec()), 32'b1000);
    @(negedge clk);
    #1 check("pre-rst taken1", 32'(taken_vec()), 32'b1000);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst taken", 32'(taken_vec()), 32'h0);
    @(posedge clk);
    #1 check_wb("rst", 1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post-rst taken0", 32'(taken_vec()), 32'b1000);
    @(posedge clk);
    #1 check_wb("post-rst", 1'b1, 1'b1, 5'd8, 32'h8888);
    @(negedge clk);
    #1 check("post-rst taken1", 32'(taken_vec()), 32'b1000);
    @(negedge clk);
    drive(4'b0000, 4'b1111, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
